div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
Sequencer and two-way arbiter that shares one combinational unsigned_div instance between two requesters. Each requester uses a valid/ready request channel. Results return on a single tagged valid/ready response channel. The block registers operands, holds them stable for a configurable settle window, and captures quotient/remainder. Divide-by-zero is resolved without using the divider.

Parameters:
WIDTH, 16, operand/result width; must match unsigned_div
SETTLE_CYCLES, 2, cycles operands drive the divider before capture; legal range >=1

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  2  bit i = requester i has an operation pending
req_ready  output  2  bit i = requester i accepted this cycle; at most one bit high
req_dividend  input  2*WIDTH  [WIDTH-1:0] = requester 0, [2*WIDTH-1:WIDTH] = requester 1
req_divisor  input  2*WIDTH  same lane packing as req_dividend
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_id  output  1  requester the response belongs to
rsp_quotient  output  WIDTH  result quotient
rsp_remainder  output  WIDTH  result remainder
rsp_div_zero  output  1  divisor was zero
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (async, any state): state=IDLE, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_div_zero=0, busy=0, settle counter=0, last_grant=1 (so requester 0 wins first).
- An in-flight operation is discarded on reset and no response is produced for it.
- IDLE, arbitration:
  - Grant g is computed combinationally.
  - Only one requester valid: that requester wins.
  - Both valid: the requester != last_grant wins (round-robin).
  - req_ready[g]=1 only in IDLE. Both req_ready bits are 0 in EXEC and RESP.
- Accept edge (req_valid[g] & req_ready[g]):
  - Latch dividend, divisor and id=g.
  - Set last_grant=g.
  - If latched divisor != 0: go to EXEC with counter=SETTLE_CYCLES-1.
  - If divisor == 0: go straight to RESP with quotient={WIDTH{1}}, remainder=dividend, div_zero=1.
- EXEC:
  - Latched operands drive unsigned_div.
  - Counter decrements each cycle.
  - At counter==0: capture divider outputs into the rsp registers, set div_zero=0, go to RESP.
- RESP:
  - rsp_valid=1.
  - All rsp_* outputs are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE. rsp_valid drops the next cycle.
  - No new accept in the same cycle as the response handshake; the earliest next accept is the following cycle.
- Latency, with the accept cycle as cycle 0:
  - Normal operation: rsp_valid first high in cycle SETTLE_CYCLES+1 (cycle 3 at default).
  - Divide-by-zero: rsp_valid first high in cycle 1.
- Operands are sampled only at the accept edge. Input changes afterwards do not affect the result.
- A requester that drops req_valid before ready is simply not granted. The bench checks that requesters hold req_valid until ready.
- rsp_quotient and rsp_remainder keep the last captured values after the handshake; they are not cleared.
- Throughput: one operation per SETTLE_CYCLES+2 cycles minimum, assuming rsp_ready is tied high.

Decomposition:
- Package div_ctrl_pkg holds:
  - state encoding localparams (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
  - default WIDTH
  - the DIV_ZERO_QUOTIENT constant (all ones)
- unsigned_div is reused unmodified as the datapath sub-instance.
- Arbitration is small enough to stay inline; no separate arbiter module.

Test Plan:
- req_valid=01, req0 100/10 -> req_ready=01 at cycle 0; rsp_valid at cycle 3; rsp_id=0, q=10, r=0, dz=0.
- After reset, req_valid=11 with req0 103/10 and req1 0xFFFF/2 -> req0 served first (q=10, r=3, id=0), then req1 (q=0x7FFF, r=1, id=1). Both valid again -> req0 granted next.
- req1 50/0 -> rsp_valid at cycle 1; id=1, q=0xFFFF, r=50, dz=1; divider output is ignored.
- req0 4321/4321 with rsp_ready=0 for 5 cycles -> rsp_valid held high with q=1, r=0 stable; req_ready=00 and busy=1 throughout; IDLE one cycle after the handshake.
- req0 12345/1, rst pulsed during EXEC -> all outputs 0 immediately and no response. Then req0 50/100 -> q=0, r=50.
- req0 0xFFFF/0xFFFF accepted, then req_dividend lane 0 changed to 0 the next cycle -> response q=1, r=0, using the latched operands.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the divider-sharing controller: FSM state encoding,
// default datapath width and the quotient reported for a zero divisor.
// ---------------------------------------------------------------------------
package div_ctrl_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Wide enough for any supported WIDTH; users slice [WIDTH-1:0].
   localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/unsigned_div.sv
// ---------------------------------------------------------------------------
// unsigned_div
// Purely combinational restoring divider.
//   dividend, divisor : WIDTH-bit unsigned operands
//   quotient          : dividend / divisor (all ones when divisor is zero)
//   remainder         : dividend % divisor (dividend when divisor is zero)
// ---------------------------------------------------------------------------
module unsigned_div #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH:0] w_rem;

   always_comb begin
      w_rem    = '0;
      quotient = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         w_rem = {w_rem[WIDTH-1:0], dividend[i]};
         if (w_rem >= {1'b0, divisor}) begin
            w_rem       = w_rem - {1'b0, divisor};
            quotient[i] = 1'b1;
         end
      end
      remainder = w_rem[WIDTH-1:0];
   end

endmodule

// File: rtl/div_share_ctrl.sv
// ---------------------------------------------------------------------------
// div_share_ctrl
// Shares one combinational unsigned_div between two requesters with
// round-robin arbitration and a single tagged response channel.
//
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   req_valid[1:0]            per-requester request valid
//   req_ready[1:0]            per-requester accept (one-hot or zero)
//   req_dividend/req_divisor  lane i in bits [i*WIDTH +: WIDTH]
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester the response belongs to
//   rsp_quotient/remainder    result, held after handshake
//   rsp_div_zero              divisor was zero
//   busy                      controller not idle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate, accept one request
// EXEC  | latched operands settle through the divider, count down
// RESP  | response presented, wait for rsp_ready
// ---------------------------------------------------------------------------
module div_share_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_dividend,
   input  logic [2*WIDTH-1:0] req_divisor,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_quotient,
   output logic [WIDTH-1:0]   rsp_remainder,
   output logic               rsp_div_zero,
   output logic               busy
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_dividend;
   logic [WIDTH-1:0]   r_divisor;
   logic               r_id;
   logic               r_last_grant;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_rsp_id;
   logic [WIDTH-1:0]   r_rsp_q;
   logic [WIDTH-1:0]   r_rsp_r;
   logic               r_rsp_dz;

   logic               w_grant;
   logic               w_accept;
   logic               w_div_zero;
   logic               w_cnt_done;
   logic [WIDTH-1:0]   w_sel_dividend;
   logic [WIDTH-1:0]   w_sel_divisor;
   logic [WIDTH-1:0]   w_div_q;
   logic [WIDTH-1:0]   w_div_r;

   // Lone requester wins; on contention the one not served last wins.
   always_comb begin
      w_grant = 1'b0;
      if (req_valid == 2'b11) begin
         w_grant = ~r_last_grant;
      end else begin
         w_grant = req_valid[1];
      end
   end

   assign w_accept       = (r_state == IDLE) && (req_valid != 2'b00);
   assign req_ready      = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
   assign w_sel_dividend = w_grant ? req_dividend[2*WIDTH-1:WIDTH] : req_dividend[WIDTH-1:0];
   assign w_sel_divisor  = w_grant ? req_divisor[2*WIDTH-1:WIDTH]  : req_divisor[WIDTH-1:0];
   assign w_div_zero     = (w_sel_divisor == '0);
   assign w_cnt_done     = (r_cnt == '0);

   unsigned_div #(
      .WIDTH (WIDTH)
   ) u_div (
      .dividend  (r_dividend),
      .divisor   (r_divisor),
      .quotient  (w_div_q),
      .remainder (w_div_r)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = w_div_zero ? RESP : EXEC;
            end
         end
         EXEC: begin
            if (w_cnt_done) begin
               w_next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dividend   <= '0;
         r_divisor    <= '0;
         r_id         <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_rsp_id     <= 1'b0;
         r_rsp_q      <= '0;
         r_rsp_r      <= '0;
         r_rsp_dz     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_dividend   <= w_sel_dividend;
                  r_divisor    <= w_sel_divisor;
                  r_id         <= w_grant;
                  r_last_grant <= w_grant;
                  r_cnt        <= CNT_INIT;
                  // Zero divisor bypasses the divider entirely.
                  if (w_div_zero) begin
                     r_rsp_id <= w_grant;
                     r_rsp_q  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                     r_rsp_r  <= w_sel_dividend;
                     r_rsp_dz <= 1'b1;
                  end
               end
            end
            EXEC: begin
               if (w_cnt_done) begin
                  r_rsp_id <= r_id;
                  r_rsp_q  <= w_div_q;
                  r_rsp_r  <= w_div_r;
                  r_rsp_dz <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid     = (r_state == RESP);
   assign rsp_id        = r_rsp_id;
   assign rsp_quotient  = r_rsp_q;
   assign rsp_remainder = r_rsp_r;
   assign rsp_div_zero  = r_rsp_dz;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_div_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_share_ctrl
// Directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model (grant rule, arithmetic result, fixed latency)
// is compared against the DUT on every clock.
// ---------------------------------------------------------------------------
module tb_div_share_ctrl;

   localparam int W      = 16;
   localparam int SETTLE = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_dividend;
   logic [2*W-1:0] req_divisor;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [W-1:0]   rsp_quotient;
   logic [W-1:0]   rsp_remainder;
   logic           rsp_div_zero;
   logic           busy;

   int errors = 0;
   int checks = 0;

   div_share_ctrl #(
      .WIDTH         (W),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_div_zero  (rsp_div_zero),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   int           cyc = 0;
   bit           m_busy;
   int           m_rsp_at;
   bit           m_last;
   bit           p_id, p_dz;
   logic [W-1:0] p_q, p_r;
   bit           s_id, s_dz;
   logic [W-1:0] s_q, s_r;

   always @(negedge clk) begin
      bit           exp_valid;
      logic [1:0]   exp_ready;
      bit           g;
      logic [W-1:0] dv, ds;
      cyc++;
      if (rst) begin
         m_busy = 0;
         m_last = 1;
         s_id = 0; s_dz = 0; s_q = '0; s_r = '0;
      end else begin
         if (m_busy && cyc == m_rsp_at) begin
            s_id = p_id; s_dz = p_dz; s_q = p_q; s_r = p_r;
         end
         exp_valid = m_busy && (cyc >= m_rsp_at);
         exp_ready = 2'b00;
         g = 0;
         if (!m_busy && req_valid != 2'b00) begin
            g = (req_valid == 2'b11) ? !m_last : req_valid[1];
            exp_ready = g ? 2'b10 : 2'b01;
         end
         chk("m_req_ready", req_ready, exp_ready);
         chk("m_busy", busy, m_busy);
         chk("m_rsp_valid", rsp_valid, exp_valid);
         chk("m_rsp_id", rsp_id, s_id);
         chk("m_rsp_quotient", rsp_quotient, s_q);
         chk("m_rsp_remainder", rsp_remainder, s_r);
         chk("m_rsp_div_zero", rsp_div_zero, s_dz);
         if (exp_ready != 2'b00) begin
            dv       = req_dividend[g*W +: W];
            ds       = req_divisor[g*W +: W];
            m_busy   = 1;
            m_last   = g;
            p_id     = g;
            p_dz     = (ds == 0);
            p_q      = p_dz ? {W{1'b1}} : dv / ds;
            p_r      = p_dz ? dv : dv % ds;
            m_rsp_at = cyc + (p_dz ? 1 : SETTLE + 1);
         end
         if (exp_valid && rsp_ready) m_busy = 0;
      end
   end

   // ---------------- directed helpers ----------------
   task automatic chk_zero_outputs(input string nm);
      chk({nm, "_rsp_valid"}, rsp_valid, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_req_ready"}, req_ready, 0);
      chk({nm, "_rsp_id"}, rsp_id, 0);
      chk({nm, "_q"}, rsp_quotient, 0);
      chk({nm, "_r"}, rsp_remainder, 0);
      chk({nm, "_dz"}, rsp_div_zero, 0);
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk_zero_outputs(nm);
      @(negedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
   endtask

   task automatic set_op(input int id, input logic [W-1:0] dv, input logic [W-1:0] ds);
      req_dividend[id*W +: W] = dv;
      req_divisor[id*W +: W]  = ds;
      req_valid[id]           = 1'b1;
   endtask

   // Returns at posedge+1 of cycle 1 with the granted valid bit dropped.
   task automatic wait_ready(input logic [1:0] exp, input string nm);
      logic [1:0] seen;
      seen = 2'b00;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         seen = req_ready;
         if (seen != 2'b00) break;
      end
      chk({nm, "_ready"}, seen, exp);
      @(posedge clk);
      #1 req_valid = req_valid & ~seen;
   endtask

   task automatic wait_rsp(input int lat, input logic id, input logic [W-1:0] q,
                           input logic [W-1:0] r, input logic dz, input string nm);
      int k;
      k = 1;
      @(negedge clk);
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_latency"}, k, lat);
      chk({nm, "_id"}, rsp_id, id);
      chk({nm, "_q"}, rsp_quotient, q);
      chk({nm, "_r"}, rsp_remainder, r);
      chk({nm, "_dz"}, rsp_div_zero, dz);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rdy_seen;
      logic [W-1:0] dv, ds;
      rst          = 1'b1;
      req_valid    = 2'b00;
      req_dividend = '0;
      req_divisor  = '0;
      rsp_ready    = 1'b1;
      #2 chk_zero_outputs("reset");
      #16 rst = 1'b0;

      // basic divide, requester 0
      @(posedge clk); #1 set_op(0, 16'd100, 16'd10);
      wait_ready(2'b01, "t1");
      wait_rsp(3, 1'b0, 16'd10, 16'd0, 1'b0, "t1");

      // round robin after reset
      do_reset("t2_reset");
      @(posedge clk); #1;
      set_op(0, 16'd103, 16'd10);
      set_op(1, 16'hFFFF, 16'd2);
      wait_ready(2'b01, "t2a");
      wait_rsp(3, 1'b0, 16'd10, 16'd3, 1'b0, "t2a");
      wait_ready(2'b10, "t2b");
      wait_rsp(3, 1'b1, 16'h7FFF, 16'd1, 1'b0, "t2b");
      @(posedge clk); #1;
      set_op(0, 16'd7, 16'd2);
      set_op(1, 16'd9, 16'd4);
      wait_ready(2'b01, "t2c");
      req_valid = 2'b00;
      wait_rsp(3, 1'b0, 16'd3, 16'd1, 1'b0, "t2c");

      // divide by zero, requester 1
      @(posedge clk); #1 set_op(1, 16'd50, 16'd0);
      wait_ready(2'b10, "t3");
      wait_rsp(1, 1'b1, 16'hFFFF, 16'd50, 1'b1, "t3");

      // back-pressure on the response
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      set_op(0, 16'd4321, 16'd4321);
      wait_ready(2'b01, "t4");
      wait_rsp(3, 1'b0, 16'd1, 16'd0, 1'b0, "t4");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 set_op(1, 16'd77, 16'd7);
         @(negedge clk);
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_hold_q", rsp_quotient, 1);
         chk("t4_hold_r", rsp_remainder, 0);
         chk("t4_hold_ready", req_ready, 2'b00);
         chk("t4_hold_busy", busy, 1);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_hs_valid", rsp_valid, 1);
      @(negedge clk);
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_valid", rsp_valid, 0);

      // reset while executing
      @(posedge clk); #1 set_op(0, 16'd12345, 16'd1);
      wait_ready(2'b01, "t5");
      do_reset("t5_reset");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_no_rsp", rsp_valid, 0);
      end
      @(posedge clk); #1 set_op(0, 16'd50, 16'd100);
      wait_ready(2'b01, "t5b");
      wait_rsp(3, 1'b0, 16'd0, 16'd50, 1'b0, "t5b");

      // operands sampled only at accept
      @(posedge clk); #1 set_op(0, 16'hFFFF, 16'hFFFF);
      wait_ready(2'b01, "t6");
      req_dividend[W-1:0] = '0;
      wait_rsp(3, 1'b0, 16'd1, 16'd0, 1'b0, "t6");

      // randomized traffic; requesters hold valid until granted
      rdy_seen = 2'b00;
      for (int c = 0; c < 800; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && rdy_seen[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               dv = W'($urandom);
               case ($urandom_range(0, 7))
                  0:       ds = '0;
                  1, 2:    ds = W'($urandom_range(1, 15));
                  default: ds = W'($urandom);
               endcase
               set_op(i, dv, ds);
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         rdy_seen = req_ready;
      end

      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("final_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
